// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: the cache line and the arbiter FSM states.
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } lc3b_arb_state;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer: f = sel ? b : a.
module mux2 #(
  parameter int width = 16
) (
  input  logic             sel,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] f
);

  // Pure combinational select.
  always_comb begin
    f = sel ? b : a;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between the I-cache and
// D-cache miss ports. One line transfer in flight at a time; the grant is
// registered and held until pmem_resp, and the response is steered back
// combinationally to the owner of the transfer.
// Build option MEM_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous I/D
// requests alternate using a last_grant bit; when undefined, D always wins.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int LINE_W = $bits(lc3b_line)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [15:0]       i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [15:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [15:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_next_state;
  lc3b_arb_state w_tie_winner;
  logic          w_i_req;
  logic          w_d_req;
  logic          w_addr_sel;
  logic [15:0]   w_i_addr;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 = D was granted most recently, 0 = I. Resets to I so D takes the first tie.
  logic r_last_grant;

  // Remember which side received the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b0;
    end else if (r_state == IDLE && w_next_state != IDLE) begin
      r_last_grant <= (w_next_state == GRANT_D);
    end
  end

  assign w_tie_winner = r_last_grant ? GRANT_I : GRANT_D;
`else
  assign w_tie_winner = GRANT_D;
`endif

  // State register; reset abandons any downstream transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: grant from IDLE, hold the grant until the downstream completes.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) begin
          w_next_state = w_tie_winner;
        end else if (w_i_req) begin
          w_next_state = GRANT_I;
        end else if (w_d_req) begin
          w_next_state = GRANT_D;
        end
      end
      GRANT_I: if (pmem_resp) w_next_state = IDLE;
      GRANT_D: if (pmem_resp) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Command and response steering; everything idles at zero outside a grant.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    i_resp     = 1'b0;
    i_rdata    = '0;
    d_resp     = 1'b0;
    d_rdata    = '0;
    case (r_state)
      GRANT_I: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp;
        i_rdata   = pmem_resp ? pmem_rdata : '0;
      end
      GRANT_D: begin
        // A writeback takes precedence over a read if both are (illegally) raised.
        pmem_read  = d_read & ~d_write;
        pmem_write = d_write;
        pmem_wdata = d_wdata;
        d_resp     = pmem_resp;
        d_rdata    = pmem_resp ? pmem_rdata : '0;
      end
      default: ;
    endcase
  end

  // Address path: I address only while I holds the grant, D address while D does.
  assign w_addr_sel = (r_state == GRANT_D);
  assign w_i_addr   = (r_state == GRANT_I) ? i_address : 16'h0000;

  mux2 #(.width(16)) u_addr_mux (
    .sel (w_addr_sel),
    .a   (w_i_addr),
    .b   (d_address),
    .f   (pmem_address)
  );

`ifndef SYNTHESIS
  // Flag the illegal simultaneous read+writeback request from the D-cache.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(d_read && d_write))
        else $warning("mem_arbiter: d_read and d_write both high, writeback takes precedence");
    end
  end
`endif

endmodule
